// File: rtl/wbc_pvic.sv
// wbc_pvic: vectored interrupt controller for the VM2 Wishbone interrupt bus.
// Collects N device requests (per-source edge or level), masks them, arbitrates
// (fixed or round-robin) and answers the CPU interrupt-acknowledge cycle with the
// winning vector, a spurious vector, or rsel on an unaddressed read.
//
// Bus handshake: the CPU raises wb_stb_i and keeps it high until it has seen
// wb_ack_o. The controller samples wb_stb_i in IDLE, answers with wb_ack_o for
// exactly one cycle on the next edge (wb_dat_o valid while wb_ack_o = 1, and held
// afterwards), then waits for wb_stb_i to fall before it accepts a new cycle.
// A strobe stretched past the ack never produces a second ack.
module wbc_pvic #(
  parameter int            N        = 3,
  parameter logic [N-1:0]  EDGE     = '0,
  parameter bit            RR       = 1'b0,
  parameter logic [15:0]   SPUR_VEC = 16'o000000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wb_stb_i,
  input  logic              wb_una_i,
  output logic              wb_ack_o,
  output logic [15:0]       wb_dat_o,
  output logic              wb_irq_o,
  input  logic [15:0]       rsel,
  input  logic [16*N-1:0]   ivec,
  input  logic [N-1:0]      ireq,
  input  logic [N-1:0]      imask,
  output logic [N-1:0]      iack,
  output logic [N-1:0]      ipend_o,
  output logic [1:0]        dbg_state
);

  // Round-robin pointer width; a single source still needs one bit.
  localparam int            PW      = (N > 1) ? $clog2(N) : 1;
  // Reset the pointer to the last source so source 0 is searched first.
  localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_q;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  prev_q;
  logic [N-1:0]  edge_pend_q;

  logic [N-1:0]  edge_set;
  logic [N-1:0]  pend;
  logic [N-1:0]  req;
  logic [N-1:0]  irq_keep;
  logic          any_req;
  logic [PW-1:0] win;
  logic [N-1:0]  win_onehot;
  logic [15:0]   win_vec;
  logic [15:0]   vec_arr [N];

  // Split the flat vector bus into one 16-bit word per source.
  for (genvar g = 0; g < N; g++) begin : g_vec
    assign vec_arr[g] = ivec[16*g +: 16];
  end

  // Rising-edge detect on edge-mode sources. prev_q resets to 0, so a request
  // already high at reset release counts as an edge.
  always_comb begin
    edge_set = ireq & ~prev_q & EDGE;
  end

  // Raw pending bits: level sources follow ireq directly, edge sources use the
  // latch. Held at zero while reset is asserted so the status drops at once.
  always_comb begin
    pend = '0;
    if (wb_rst_n_i) begin
      pend = (edge_pend_q & EDGE) | (ireq & ~EDGE);
    end
    req = pend & imask;
  end

  // Requests that still count toward wb_irq_o after this edge: an edge source
  // being acknowledged now (and not re-triggered in the same cycle) drops out
  // immediately, so the CPU does not see a stale irq for one extra cycle.
  always_comb begin
    irq_keep = req & ~(iack & EDGE & ~edge_set);
  end

  // Arbiter: fixed priority scans from source 0 upward; round-robin scans
  // upward starting just after the previous winner, wrapping at N.
  always_comb begin
    int            idx;
    logic [PW-1:0] sel;
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = RR ? ((int'(ptr_q) + 1 + k) % N) : k;
      sel = PW'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        win     = sel;
      end
    end
  end

  // Winner decode: one-hot acknowledge pattern and the selected vector word.
  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    win_vec         = vec_arr[win];
  end

  // Edge pending latches and previous-request history; a new edge beats a
  // simultaneous acknowledge so a re-trigger during iack is never lost.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      prev_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      prev_q      <= ireq;
      edge_pend_q <= ((edge_pend_q & ~iack) | edge_set) & EDGE;
    end
  end

  // Registered interrupt request to the CPU.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_irq_o <= 1'b0;
    end else begin
      wb_irq_o <= |irq_keep;
    end
  end

  // Acknowledge-cycle FSM: sample the strobe in IDLE, freeze the answer, give a
  // single ack (with iack) in ACK, then wait in HOLD for the strobe to drop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      iack     <= '0;
      ptr_q    <= PTR_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_stb_i) begin
            state_q  <= ST_ACK;
            wb_ack_o <= 1'b1;
            if (wb_una_i) begin
              wb_dat_o <= rsel;
            end else if (any_req) begin
              wb_dat_o <= win_vec;
              iack     <= win_onehot;
              if (RR) begin
                ptr_q <= win;
              end
            end else begin
              wb_dat_o <= SPUR_VEC;
            end
          end
        end
        ST_ACK: begin
          wb_ack_o <= 1'b0;
          iack     <= '0;
          state_q  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!wb_stb_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          wb_ack_o <= 1'b0;
          iack     <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ipend_o   = pend;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wbc_pvic.sv
// tb_wbc_pvic: two controller instances (fixed priority with source 2 in edge
// mode and a non-zero spurious vector; round-robin with all-level sources) share
// one stimulus stream. A behavioural model built from the controller's rules
// predicts every output each cycle; a per-instance expected queue holds the
// vector each acknowledge must deliver.
module tb_wbc_pvic;

  localparam logic [15:0] V0 = 16'o000064;
  localparam logic [15:0] V1 = 16'o000060;
  localparam logic [15:0] V2 = 16'o000054;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stb;
  logic        una;
  logic [15:0] rsel;
  logic [47:0] ivec;
  logic [2:0]  ireq;
  logic [2:0]  imask;

  logic        ack0, ack1, irq0, irq1;
  logic [15:0] dat0, dat1;
  logic [2:0]  iack0, iack1, ipend0, ipend1;
  logic [1:0]  st0, st1;

  wbc_pvic #(.N(3), .EDGE(3'b100), .RR(1'b0), .SPUR_VEC(16'o000777)) dut_fix (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_stb_i(stb), .wb_una_i(una),
    .wb_ack_o(ack0), .wb_dat_o(dat0), .wb_irq_o(irq0), .rsel(rsel), .ivec(ivec),
    .ireq(ireq), .imask(imask), .iack(iack0), .ipend_o(ipend0), .dbg_state(st0)
  );

  wbc_pvic #(.N(3), .EDGE(3'b000), .RR(1'b1), .SPUR_VEC(16'o000000)) dut_rr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_stb_i(stb), .wb_una_i(una),
    .wb_ack_o(ack1), .wb_dat_o(dat1), .wb_irq_o(irq1), .rsel(rsel), .ivec(ivec),
    .ireq(ireq), .imask(imask), .iack(iack1), .ipend_o(ipend1), .dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_errors;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  // Model state per instance (0 = fixed/edge2, 1 = round-robin/level)
  logic [2:0]  m_pe   [2];
  logic [2:0]  m_prev [2];
  logic [2:0]  m_iack [2];
  logic        m_irq  [2];
  logic        m_ack  [2];
  logic [15:0] m_dat  [2];
  int          m_phase[2];  // 0 waiting for strobe, 1 acknowledging, 2 waiting for strobe low
  int          m_ptr  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2:0] edge_of(input int d);
    return (d == 0) ? 3'b100 : 3'b000;
  endfunction

  function automatic logic [15:0] spur_of(input int d);
    return (d == 0) ? 16'o000777 : 16'o000000;
  endfunction

  function automatic logic [15:0] vec_of(input int i);
    case (i)
      0:       return V0;
      1:       return V1;
      default: return V2;
    endcase
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input int i);
    logic [2:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [2:0] model_pend(input int d);
    return (m_pe[d] & edge_of(d)) | (ireq & ~edge_of(d));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pe[d] = '0; m_prev[d] = '0; m_iack[d] = '0;
      m_irq[d] = 1'b0; m_ack[d] = 1'b0; m_dat[d] = '0;
      m_phase[d] = 0; m_ptr[d] = 2;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One rising clock edge of instance d, from the inputs present before the edge.
  task automatic model_step(input int d);
    logic [2:0] eg, req, set_v, cleared, npe;
    int win, idx;
    eg      = edge_of(d);
    req     = model_pend(d) & imask;
    set_v   = ireq & ~m_prev[d] & eg;
    cleared = eg & m_iack[d] & ~set_v;        // edge bits retired by this edge
    npe     = ((m_pe[d] & ~m_iack[d]) | set_v) & eg;
    case (m_phase[d])
      0: begin
        if (stb) begin
          m_phase[d] = 1;
          m_ack[d]   = 1'b1;
          m_iack[d]  = '0;
          if (una) begin
            m_dat[d] = rsel;
          end else begin
            win = -1;
            for (int k = 0; k < 3; k++) begin
              idx = (d == 1) ? (m_ptr[d] + 1 + k) % 3 : k;
              if (win < 0 && bit_at(req, idx)) win = idx;
            end
            if (win >= 0) begin
              m_dat[d]  = vec_of(win);
              m_iack[d] = 3'b001 << win;
              if (d == 1) m_ptr[d] = win;
            end else begin
              m_dat[d] = spur_of(d);
            end
          end
          if (d == 0) exp_q0.push_back(m_dat[d]);
          else        exp_q1.push_back(m_dat[d]);
        end
      end
      1: begin
        m_ack[d]   = 1'b0;
        m_iack[d]  = '0;
        m_phase[d] = 2;
      end
      default: begin
        if (!stb) m_phase[d] = 0;
      end
    endcase
    m_irq[d]  = |(req & ~cleared);
    m_pe[d]   = npe;
    m_prev[d] = ireq;
  endtask

  task automatic compare(input int d);
    logic g_ack, g_irq;
    logic [2:0] g_iack, g_ipend, e_pend;
    logic [15:0] g_dat;
    if (d == 0) begin
      g_ack = ack0; g_irq = irq0; g_iack = iack0; g_ipend = ipend0; g_dat = dat0;
    end else begin
      g_ack = ack1; g_irq = irq1; g_iack = iack1; g_ipend = ipend1; g_dat = dat1;
    end
    e_pend = rst_n ? model_pend(d) : 3'b000;
    check($sformatf("d%0d_ack", d),   32'(g_ack),   32'(m_ack[d]));
    check($sformatf("d%0d_iack", d),  32'(g_iack),  32'(m_iack[d]));
    check($sformatf("d%0d_irq", d),   32'(g_irq),   32'(m_irq[d]));
    check($sformatf("d%0d_ipend", d), 32'(g_ipend), 32'(e_pend));
    check($sformatf("d%0d_dat", d),   32'(g_dat),   32'(m_dat[d]));
    if (g_ack) begin
      if (d == 0) begin
        if (exp_q0.size() == 0) check("d0_sb_extra_ack", 32'(g_ack), 32'(0));
        else                    check("d0_sb_vec", 32'(g_dat), 32'(exp_q0.pop_front()));
      end else begin
        if (exp_q1.size() == 0) check("d1_sb_extra_ack", 32'(g_ack), 32'(0));
        else                    check("d1_sb_vec", 32'(g_dat), 32'(exp_q1.pop_front()));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Vector fetch / una cycle; optionally re-raises ireq bits on the iack cycle.
  task automatic fetch(input logic una_v, input logic [15:0] rsel_v, input logic [2:0] reassert,
                       output logic [15:0] v0, output logic [15:0] v1,
                       output logic [2:0] ia0, output logic [2:0] ia1);
    int n;
    stb = 1'b1; una = una_v; rsel = rsel_v;
    n = 0;
    while (!ack0 && n < 6) begin
      tick();
      n++;
    end
    check("fetch_ack_seen", 32'(ack0), 32'(1));
    v0 = dat0; v1 = dat1; ia0 = iack0; ia1 = iack1;
    stb = 1'b0; una = 1'b0;
    ireq = ireq | reassert;
    tick();
    ireq = ireq & ~reassert;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] v0, v1;
    logic [2:0]  ia0, ia1;
    logic [15:0] rr_exp [4];
    int          cnt;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; stb = 1'b0; una = 1'b0; rsel = '0;
    ireq = '0; imask = '0;
    ivec = {V2, V1, V0};
    model_reset();
    tick();
    tick();
    check("rst_state", 32'(st0), 32'(0));
    rst_n = 1'b1;
    tick();

    // 1: fixed priority, level requests on sources 1 and 2
    reset_all();
    imask = 3'b111; ireq = 3'b110;
    tick();
    fetch(1'b0, 16'o0, 3'b000, v0, v1, ia0, ia1);
    check("t1_vec_fix", 32'(v0), 32'(16'o000060));
    check("t1_iack_fix", 32'(ia0), 32'(3'b010));
    check("t1_vec_rr", 32'(v1), 32'(16'o000060));
    ireq = 3'b000;
    tick();

    // 2: round-robin rotation with all three requests held
    reset_all();
    rr_exp[0] = V0; rr_exp[1] = V1; rr_exp[2] = V2; rr_exp[3] = V0;
    imask = 3'b111; ireq = 3'b111;
    tick();
    for (int j = 0; j < 4; j++) begin
      fetch(1'b0, 16'o0, 3'b000, v0, v1, ia0, ia1);
      check($sformatf("t2_rr_vec%0d", j), 32'(v1), 32'(rr_exp[j]));
      check($sformatf("t2_fix_vec%0d", j), 32'(v0), 32'(V0));
    end
    ireq = 3'b000;
    tick();

    // 3: edge pulse while masked, then unmask and fetch
    reset_all();
    imask = 3'b011; ireq = 3'b000;
    tick(); tick();
    ireq = 3'b100; tick();
    ireq = 3'b000; tick(); tick();
    check("t3_pend_masked", 32'(ipend0[2]), 32'(1));
    check("t3_irq_masked", 32'(irq0), 32'(0));
    imask = 3'b111;
    tick();
    check("t3_irq_unmask", 32'(irq0), 32'(1));
    fetch(1'b0, 16'o0, 3'b000, v0, v1, ia0, ia1);
    check("t3_vec", 32'(v0), 32'(V2));
    check("t3_iack", 32'(ia0), 32'(3'b100));
    check("t3_pend_clr", 32'(ipend0[2]), 32'(0));
    check("t3_irq_drop", 32'(irq0), 32'(0));

    // 4: edge re-asserted on the iack cycle survives the clear
    ireq = 3'b100; tick();
    ireq = 3'b000; tick();
    fetch(1'b0, 16'o0, 3'b100, v0, v1, ia0, ia1);
    check("t4_vec", 32'(v0), 32'(V2));
    check("t4_pend_kept", 32'(ipend0[2]), 32'(1));
    check("t4_irq_kept", 32'(irq0), 32'(1));
    fetch(1'b0, 16'o0, 3'b000, v0, v1, ia0, ia1);
    check("t4_pend_clr", 32'(ipend0[2]), 32'(0));

    // 5: spurious vector and unaddressed reads
    reset_all();
    imask = 3'b111; ireq = 3'b000;
    tick();
    fetch(1'b0, 16'o0, 3'b000, v0, v1, ia0, ia1);
    check("t5_spur_fix", 32'(v0), 32'(16'o000777));
    check("t5_spur_iack", 32'(ia0), 32'(0));
    fetch(1'b1, 16'o000000, 3'b000, v0, v1, ia0, ia1);
    check("t5_una_zero", 32'(v0), 32'(16'o000000));
    ireq = 3'b011;
    tick();
    fetch(1'b1, 16'o123456, 3'b000, v0, v1, ia0, ia1);
    check("t5_una_fix", 32'(v0), 32'(16'o123456));
    check("t5_una_rr", 32'(v1), 32'(16'o123456));
    check("t5_una_iack", 32'(ia0), 32'(0));
    ireq = 3'b000;
    tick();

    // 6: stretched strobe gives one ack; async reset during ACK
    ireq = 3'b011;
    tick();
    stb = 1'b1; cnt = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (ack0) cnt++;
    end
    stb = 1'b0;
    check("t6_single_ack", 32'(cnt), 32'(1));
    tick(); tick();
    stb = 1'b1;
    tick();
    check("t6_ack_before_rst", 32'(ack0), 32'(1));
    check("t6_iack_before_rst", 32'(iack0), 32'(3'b001));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", 32'(ack0), 32'(0));
    check("t6_rst_iack", 32'(iack0), 32'(0));
    check("t6_rst_pend", 32'(ipend0), 32'(0));
    check("t6_rst_pend_rr", 32'(ipend1), 32'(0));
    model_reset();
    stb = 1'b0; ireq = 3'b000;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    reset_all();
    for (int c = 0; c < 400; c++) begin
      ireq  = 3'($urandom_range(0, 7));
      imask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      if (!stb && m_phase[0] == 0 && $urandom_range(0, 2) == 0) begin
        stb  = 1'b1;
        una  = ($urandom_range(0, 4) == 0);
        rsel = 16'($urandom);
      end else if (stb && m_phase[0] != 0 && $urandom_range(0, 1) == 0) begin
        stb = 1'b0;
        una = 1'b0;
      end
      tick();
    end
    stb = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
